periodmeter: RTL
================

# periodmeter

Measures the period and high time of a slow external square wave, such as a generated baud/bit clock or a link line, in cycles of the system clock. It is the receiving-side counterpart of the clock generator: the generator produces a divided clock, and this block recovers the divide ratio from a clock or line seen at a pin. It sits between an unsynchronized input pin and the link/UART control logic, which consumes one result per input period through a valid pulse.

## Interface
- c_MAXTICKS, default 65535: longest period counted, in i_clock cycles; also the timeout threshold.
- c_WIDTH, default $clog2(c_MAXTICKS+1): width of the count outputs. Derived; do not override.
- i_clock  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  synchronous reset, active-high.
- i_signal  input  1  asynchronous square wave being measured.
- o_period  output  c_WIDTH  cycles between the last two detected rising edges.
- o_high  output  c_WIDTH  cycles from the first rising edge of the last period to its falling edge.
- o_valid  output  1  one-cycle pulse; o_period and o_high updated this cycle.
- o_timeout  output  1  level; no rising edge seen within c_MAXTICKS cycles.

## Operation
- The input passes through a 2-flop synchronizer (r_SYNC1, r_SYNC2), then r_PREV.
  - Rise = r_SYNC2 & !r_PREV; fall = !r_SYNC2 & r_PREV.
  - All three flops reset to 0, so a pin held high through reset yields one rise after release.
- States:
  - IDLE (reset state): waits for a rise. On rise: r_COUNT <= 1, clear o_timeout, go to MEASURE. No o_valid.
  - MEASURE:
    - Each cycle without a rise: r_COUNT <= r_COUNT+1.
    - On fall: r_HIGHCAP <= r_COUNT.
    - On rise: o_period <= r_COUNT, o_high <= r_HIGHCAP, o_valid <= 1, r_COUNT <= 1, stay in MEASURE.
- With rises detected at cycles t and t+N, o_period = N and o_high = cycles from rise to fall.
- Timeout: in MEASURE, if r_COUNT == c_MAXTICKS and there is no rise this cycle:
  - o_timeout <= 1, o_period <= 0, o_high <= 0, go to IDLE, no o_valid.
  - r_COUNT never exceeds c_MAXTICKS, so it cannot wrap.
- Simultaneous rise and r_COUNT == c_MAXTICKS: the rise wins and a valid result of c_MAXTICKS is produced.
- A rise and a fall cannot occur in the same cycle.
- No fall within a period (only possible if the input glitches below synchronizer resolution): r_HIGHCAP keeps its previous value.
- o_period and o_high hold their value between o_valid pulses.

## Timing
- Reset values: o_period=0, o_high=0, o_valid=0, o_timeout=0, state IDLE, r_COUNT=0, r_HIGHCAP=0.
- Reset asserted mid-measurement returns everything to reset values on the next i_clock edge. No o_valid is emitted for the partial period.
- Latency, with the first i_clock edge sampling i_signal high as edge k:
  - r_SYNC2=1 after k+1.
  - The rise is seen during the cycle after k+1.
  - o_valid is high for the one cycle following edge k+2.
- o_timeout rises on the edge after the counter reaches c_MAXTICKS. It falls together with the IDLE→MEASURE transition.
- Minimum measurable period is 2 cycles, with high and low each at least 1 synchronized cycle. Shorter pulses may be missed.
- Throughput: one result per input period. No backpressure; the consumer samples on o_valid.

## Test plan
- Reset, then i_signal square wave with period 40000 and high time 20000 → first rise produces no o_valid. Every later rise produces o_valid with o_period=40000 and o_high=20000.
- Asymmetric wave, high 3 / low 7 cycles → o_period=10, o_high=3 on each pulse, pulses exactly 10 cycles apart.
- c_MAXTICKS=1000, single rise then i_signal stuck low → o_timeout=1 exactly 1000 cycles after the rise, with o_period=o_high=0. The next rise clears o_timeout, with no o_valid. The following period reports correctly.
- c_MAXTICKS=1000, period exactly 1000 → o_valid with o_period=1000 and o_timeout stays 0. With period 1001 → timeout, no o_valid.
- Assert i_reset mid-period of a 40000-cycle wave → all outputs 0 on the next edge. The first rise after release gives no o_valid; the second gives o_period=40000.
- i_signal held high through reset and after release → exactly one rise accepted (IDLE→MEASURE), no o_valid, and timeout after c_MAXTICKS cycles.

Source files
------------

// File: rtl/periodmeter.sv
// periodmeter: measures period and high time of a slow asynchronous square wave in i_clock cycles.
module periodmeter #(
  parameter int c_MAXTICKS = 65535,
  parameter int c_WIDTH = $clog2(c_MAXTICKS + 1)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_signal,
  output logic [c_WIDTH-1:0] o_period,
  output logic [c_WIDTH-1:0] o_high,
  output logic               o_valid,
  output logic               o_timeout
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [c_WIDTH-1:0] c_MAX = c_WIDTH'(c_MAXTICKS);
  localparam logic [c_WIDTH-1:0] c_ONE = c_WIDTH'(1);
  state_t r_state, w_state;
  logic r_sync1, r_sync2, r_prev;
  logic [c_WIDTH-1:0] r_count, r_highcap, w_count, w_highcap, w_period, w_high;
  logic w_valid, w_timeout, w_rise, w_fall;
  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;
  // A rise always wins over the timeout so a period of exactly c_MAXTICKS is still reported.
  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_highcap = r_highcap;
    w_period = o_period;
    w_high = o_high;
    w_valid = 1'b0;
    w_timeout = o_timeout;
    if (r_state == IDLE) begin
      if (w_rise) begin
        w_count = c_ONE;
        w_timeout = 1'b0;
        w_state = MEASURE;
      end
    end else if (w_rise) begin
      w_period = r_count;
      w_high = r_highcap;
      w_valid = 1'b1;
      w_count = c_ONE;
    end else if (r_count == c_MAX) begin
      w_timeout = 1'b1;
      w_period = '0;
      w_high = '0;
      w_state = IDLE;
    end else begin
      w_count = r_count + c_ONE;
      w_highcap = w_fall ? r_count : r_highcap;
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev <= 1'b0;
      r_state <= IDLE;
      r_count <= '0;
      r_highcap <= '0;
      o_period <= '0;
      o_high <= '0;
      o_valid <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      r_sync1 <= i_signal;
      r_sync2 <= r_sync1;
      r_prev <= r_sync2;
      r_state <= w_state;
      r_count <= w_count;
      r_highcap <= w_highcap;
      o_period <= w_period;
      o_high <= w_high;
      o_valid <= w_valid;
      o_timeout <= w_timeout;
    end
  end
endmodule
